// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-ported RAM between the fetch port and the load/store port.
// One transaction in flight; data port has priority, bounded by a starvation counter for fetch.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_ubhw,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  input  logic        flush,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_ubhw,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [LW-1:0]   r_cnt;
  logic [SW-1:0]   r_starve;
  logic            r_owner_if;
  logic            r_cancel;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [2:0]      r_ubhw;
  logic [31:0]     r_if_rdata;
  logic [31:0]     r_dm_rdata;

  logic            w_arb;
  logic            w_force_if;
  logic            w_if_win;
  logic            w_dm_win;
  logic            w_capture;

  // Reset also gates the grants so nothing is accepted while rst is low.
  assign w_arb      = rst && (r_state == S_IDLE || r_state == S_RESP);
  assign w_force_if = (STARVE_LIMIT != 0) && (r_starve == SW'(STARVE_LIMIT));
  assign w_if_win   = w_arb && if_req && (!dm_req || w_force_if);
  assign w_dm_win   = w_arb && dm_req && !w_if_win;
  assign w_capture  = (r_state == S_WAIT) && (r_cnt == LW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_if_win || w_dm_win) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_capture) w_next = S_RESP;
      S_RESP:  w_next = (w_if_win || w_dm_win) ? S_ISSUE : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = w_if_win;
    dm_gnt    = w_dm_win;
    mem_en    = (r_state == S_ISSUE);
    mem_we    = (r_state == S_ISSUE) && r_we;
    if_rvalid = (r_state == S_RESP) && r_owner_if && !r_cancel && !flush;
    dm_rvalid = (r_state == S_RESP) && !r_owner_if;
    busy      = (r_state != S_IDLE);
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_ubhw  = r_ubhw;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_starve   <= '0;
      r_owner_if <= 1'b0;
      r_cancel   <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ubhw     <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      // Fetches are always word reads.
      if (w_if_win) begin
        r_owner_if <= 1'b1;
        r_we       <= 1'b0;
        r_addr     <= if_addr;
        r_wdata    <= '0;
        r_ubhw     <= 3'b010;
      end else if (w_dm_win) begin
        r_owner_if <= 1'b0;
        r_we       <= dm_we;
        r_addr     <= dm_addr;
        r_wdata    <= dm_wdata;
        r_ubhw     <= dm_ubhw;
      end

      if (w_if_win)
        r_starve <= '0;
      else if (w_dm_win && if_req && r_starve != SW'(STARVE_LIMIT))
        r_starve <= r_starve + SW'(1);

      if (r_state == S_ISSUE)     r_cnt <= LW'(MEM_LAT);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - LW'(1);

      if (w_capture) begin
        if (r_owner_if) r_if_rdata <= mem_rdata;
        else            r_dm_rdata <= r_we ? '0 : mem_rdata;
      end

      if (r_state == S_RESP)
        r_cancel <= 1'b0;
      else if ((r_state == S_ISSUE || r_state == S_WAIT) && r_owner_if && flush)
        r_cancel <= 1'b1;
    end
  end

endmodule
